// File: rtl/watch_ctrl.sv
// HH:MM:SS time-of-day controller for the six-digit display.
// Has a CLOCK mode and a SET mode; in SET mode the field being edited blinks.
module watch_ctrl #(
  parameter int unsigned BLINK_CYC = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_up,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_sel,
  output logic [5:0] o_blank,
  output logic [5:0] o_dp
);

  typedef enum logic {CLOCK = 1'b0, SET = 1'b1} state_t;

  localparam logic [5:0]  DP_CLOCK = 6'b010100;
  localparam logic [1:0]  SEL_SEC  = 2'd0;
  localparam logic [1:0]  SEL_MIN  = 2'd1;
  localparam logic [1:0]  SEL_HOUR = 2'd2;
  localparam logic [31:0] CNT_LAST = 32'(BLINK_CYC - 1);

  state_t      state;
  logic [31:0] cnt;
  logic        phase;

  function automatic logic [5:0] inc59(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc23(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] field_mask(input logic [1:0] s);
    case (s)
      SEL_SEC:  return 6'b000011;
      SEL_MIN:  return 6'b001100;
      SEL_HOUR: return 6'b110000;
      default:  return 6'b000000;
    endcase
  endfunction

  assign o_mode = (state == SET);

  // o_blank is updated only when phase or sel changes, so it always tracks them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLOCK;
      o_sec   <= '0;
      o_min   <= '0;
      o_hour  <= '0;
      o_sel   <= SEL_SEC;
      cnt     <= '0;
      phase   <= 1'b0;
      o_blank <= '0;
      o_dp    <= DP_CLOCK;
    end else if (i_btn_mode) begin
      cnt     <= '0;
      phase   <= 1'b0;
      o_blank <= '0;
      if (state == CLOCK) begin
        state <= SET;
        o_sel <= SEL_SEC;
        o_dp  <= '0;
      end else begin
        state <= CLOCK;
        o_dp  <= DP_CLOCK;
      end
    end else if (state == CLOCK) begin
      if (i_tick) begin
        o_sec <= inc59(o_sec);
        if (o_sec == 6'd59) begin
          o_min <= inc59(o_min);
          if (o_min == 6'd59) o_hour <= inc23(o_hour);
        end
      end
    end else begin
      // Edits use the field selected before any same-cycle pos advance.
      if (i_btn_up) begin
        case (o_sel)
          SEL_SEC:  o_sec  <= inc59(o_sec);
          SEL_MIN:  o_min  <= inc59(o_min);
          SEL_HOUR: o_hour <= inc23(o_hour);
          default:  ;
        endcase
      end
      if (i_btn_pos) o_sel <= (o_sel == SEL_HOUR) ? SEL_SEC : o_sel + 2'd1;
      if (i_btn_up || i_btn_pos) begin
        cnt     <= '0;
        phase   <= 1'b0;
        o_blank <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        phase   <= ~phase;
        o_blank <= phase ? 6'b000000 : field_mask(o_sel);
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: a behavioural model pushes the expected outputs
// for each driven cycle, and they are popped and compared after the clock edge.
module tb_watch_ctrl;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_tick = 1'b0, i_btn_mode = 1'b0, i_btn_pos = 1'b0, i_btn_up = 1'b0;
  logic [5:0] o_sec, o_min, o_blank, o_dp;
  logic [4:0] o_hour;
  logic       o_mode;
  logic [1:0] o_sel;

  watch_ctrl #(.BLINK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn_mode(i_btn_mode),
    .i_btn_pos(i_btn_pos), .i_btn_up(i_btn_up), .o_sec(o_sec), .o_min(o_min),
    .o_hour(o_hour), .o_mode(o_mode), .o_sel(o_sel), .o_blank(o_blank), .o_dp(o_dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec, min, hour, mode, sel, blank, dp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  // behavioural model state
  int m_sec, m_min, m_hour, m_mode, m_sel, m_cnt, m_phase;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mask_of(input int s);
    return (s == 0) ? 6'b000011 : (s == 1) ? 6'b001100 : 6'b110000;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.sec = m_sec; e.min = m_min; e.hour = m_hour; e.mode = m_mode; e.sel = m_sel;
    e.blank = (m_mode == 1 && m_phase == 1) ? mask_of(m_sel) : 0;
    e.dp = (m_mode == 1) ? 0 : 6'b010100;
    return e;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_sel = 0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit t, input bit md, input bit p, input bit u);
    if (md) begin
      m_mode = 1 - m_mode;
      if (m_mode == 1) m_sel = 0;
      m_cnt = 0; m_phase = 0;
    end else if (m_mode == 0) begin
      if (t) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0; m_min = m_min + 1;
          if (m_min == 60) begin
            m_min = 0; m_hour = (m_hour + 1) % 24;
          end
        end
      end
    end else begin
      if (u) begin
        if (m_sel == 0) m_sec = (m_sec + 1) % 60;
        else if (m_sel == 1) m_min = (m_min + 1) % 60;
        else m_hour = (m_hour + 1) % 24;
      end
      if (p) m_sel = (m_sel + 1) % 3;
      if (u || p) begin
        m_cnt = 0; m_phase = 0;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == BC) begin
          m_cnt = 0; m_phase = 1 - m_phase;
        end
      end
    end
  endtask

  task automatic compare_out(input string pfx, input exp_t e);
    chk({pfx, "_sec"}, o_sec, e.sec);
    chk({pfx, "_min"}, o_min, e.min);
    chk({pfx, "_hour"}, o_hour, e.hour);
    chk({pfx, "_mode"}, o_mode, e.mode);
    chk({pfx, "_sel"}, o_sel, e.sel);
    chk({pfx, "_blank"}, o_blank, e.blank);
    chk({pfx, "_dp"}, o_dp, e.dp);
  endtask

  task automatic step(input bit t, input bit md, input bit p, input bit u);
    exp_t e;
    @(negedge clk);
    i_tick = t; i_btn_mode = md; i_btn_pos = p; i_btn_up = u;
    model_step(t, md, p, u);
    q.push_back(snap());
    @(posedge clk);
    #1;
    i_tick = 0; i_btn_mode = 0; i_btn_pos = 0; i_btn_up = 0;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      compare_out("cyc", e);
    end
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    compare_out("rst", snap());
    @(negedge clk);
    rst_n = 1'b1;

    // 61 ticks -> 00:01:01
    for (int i = 0; i < 61; i++) step(1, 0, 0, 0);
    chk("t61_sec", o_sec, 1);
    chk("t61_min", o_min, 1);
    chk("t61_hour", o_hour, 0);
    chk("t61_dp", o_dp, 6'b010100);
    chk("t61_blank", o_blank, 0);

    // preload 23:59:59 through SET, then roll over with one tick
    step(0, 1, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    ups(23);
    step(0, 0, 1, 0);
    ups(58);
    step(0, 0, 1, 0);
    ups(58);
    step(0, 1, 0, 0);
    chk("pre_hour", o_hour, 23);
    chk("pre_min", o_min, 59);
    chk("pre_sec", o_sec, 59);
    step(1, 0, 0, 0);
    chk("roll_hour", o_hour, 0);
    chk("roll_min", o_min, 0);
    chk("roll_sec", o_sec, 0);

    // hour edit with ticks that must be ignored
    step(0, 1, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("sel2", o_sel, 2);
    for (int i = 0; i < 25; i++) step(i % 3 == 0, 0, 0, 1);
    chk("hour25", o_hour, 1);
    chk("hour25_sec", o_sec, 0);
    chk("hour25_min", o_min, 0);

    // blink on the minute field, then an up forces it visible
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("sel1", o_sel, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("blink_on", o_blank, 6'b001100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("blink_off", o_blank, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("blink_on2", o_blank, 6'b001100);
    step(0, 0, 0, 1);
    chk("up_unblank", o_blank, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // back to CLOCK, then mode+tick+up together
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    begin
      int s0, m0, h0;
      s0 = m_sec; m0 = m_min; h0 = m_hour;
      step(1, 1, 0, 1);
      chk("prio_mode", o_mode, 1);
      chk("prio_sec", o_sec, s0);
      chk("prio_min", o_min, m0);
      chk("prio_hour", o_hour, h0);
    end

    // sec -> 59, then pos+up together
    while (m_sec != 59) step(0, 0, 0, 1);
    begin
      int m0;
      m0 = m_min;
      step(0, 0, 1, 1);
      chk("posup_sec", o_sec, 0);
      chk("posup_sel", o_sel, 1);
      chk("posup_min", o_min, m0);
    end

    // random mixed traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);

    // asynchronous reset while in SET
    if (m_mode == 0) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    ups(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mode", o_mode, 0);
    chk("arst_sec", o_sec, 0);
    chk("arst_min", o_min, 0);
    chk("arst_hour", o_hour, 0);
    chk("arst_sel", o_sel, 0);
    chk("arst_blank", o_blank, 0);
    chk("arst_dp", o_dp, 6'b010100);
    model_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_ctrl.md
Name: watch_ctrl

Overview:
- Control block for the six-digit seven-segment clock display. Sequences an HH:MM:SS time-of-day counter from an external 1 Hz tick.
- Provides a button-driven SET mode for editing hours, minutes and seconds, with the field being edited blinking.
- Feeds the digit-split, FND decode and LED multiplex stages: it outputs three binary fields, a per-digit blank mask and a per-digit decimal-point mask.

Parameters:
- BLINK_CYC, 25000000: clk cycles per blink half-period. Blink phase toggles every BLINK_CYC cycles. Use 32-bit arithmetic; legal range is 1 or more.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- i_tick, input, 1: one-cycle pulse at 1 Hz (from NCO pulse logic).
- i_btn_mode, input, 1: one-cycle pulse (debounced). Toggles CLOCK/SET mode.
- i_btn_pos, input, 1: one-cycle pulse. Selects the next field in SET mode.
- i_btn_up, input, 1: one-cycle pulse. Increments the selected field in SET mode.
- o_sec, output, 6: seconds, 0..59.
- o_min, output, 6: minutes, 0..59.
- o_hour, output, 5: hours, 0..23.
- o_mode, output, 1: 0 = CLOCK, 1 = SET.
- o_sel, output, 2: selected field. 0 = SEC, 1 = MIN, 2 = HOUR.
- o_blank, output, 6: per-digit blank mask. Bits [1:0] = sec, [3:2] = min, [5:4] = hour. 1 means the digit is blanked.
- o_dp, output, 6: per-digit decimal-point enable, same bit mapping as o_blank.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal registers clear immediately.
  - o_sec = o_min = o_hour = 0.
  - State = CLOCK, o_sel = 0.
  - Blink counter = 0, blink phase = 0.
  - o_blank = 0, o_dp = 6'b010100.
- Reset mid-edit discards the SET state entirely.
- All outputs are registered. Every input event is reflected on the outputs one clock after the rising edge at which it is sampled high. Every cycle in which an input is high counts as one event.
- State machine, two states:
  - CLOCK --i_btn_mode--> SET. On entry: o_sel = SEC, blink counter = 0, phase = 0.
  - SET --i_btn_mode--> CLOCK. o_sel holds its value but is ignored.
- CLOCK state:
  - i_tick increments the time with carry: sec 59 -> 0 increments min; min 59 -> 0 increments hour; hour 23 -> 0. Rollover 23:59:59 -> 00:00:00 happens in a single cycle.
  - i_btn_pos and i_btn_up are ignored.
- SET state:
  - i_tick is ignored; time is frozen.
  - i_btn_pos cycles o_sel: 0 -> 1 -> 2 -> 0. Value 3 is never produced.
  - i_btn_up increments the selected field only, with no carry into other fields: sec 59 -> 0, min 59 -> 0, hour 23 -> 0.
- Simultaneous events in the same cycle:
  - i_btn_mode has priority; i_btn_pos, i_btn_up and i_tick are ignored that cycle. This holds even when the transition is CLOCK -> SET with a tick present: that tick is lost.
  - i_btn_pos together with i_btn_up in SET: the increment applies to the currently selected field (before the change), and o_sel advances.
- Blink:
  - In SET, the blink counter counts 0..BLINK_CYC-1. On wrap, phase toggles.
  - o_blank = 2'b11 on the selected field's bit pair when phase = 1; all other bits are 0.
  - Any i_btn_up or i_btn_pos in SET clears the counter and forces phase = 0, so an edited field is immediately visible.
  - In CLOCK, the counter is held at 0, phase = 0, and o_blank = 0.
- Decimal points:
  - o_dp = 6'b010100 in CLOCK (separators after the hour and min digits).
  - o_dp = 6'b000000 in SET.
- Width rule: increments compare against the terminal value (59 or 23) rather than relying on natural overflow. Out-of-range values are unreachable.

Test Plan:
- Reset, then 61 i_tick pulses in CLOCK -> o_sec = 1, o_min = 1, o_hour = 0, o_dp = 6'b010100, o_blank = 0.
- Preload to 23:59:59 via SET, return to CLOCK, then one i_tick -> next cycle shows 00:00:00.
- Enter SET; i_btn_pos x2 -> o_sel = 2. i_btn_up x25 -> o_hour = 1 (wrapped at 23), o_min and o_sec unchanged. i_tick pulses during this sequence leave o_sec unchanged.
- With BLINK_CYC = 4, in SET with o_sel = 1 -> o_blank toggles between 0 and 6'b001100 every 4 cycles. An i_btn_up forces o_blank = 0 on the next cycle.
- i_btn_mode asserted together with i_tick and i_btn_up in CLOCK -> o_mode = 1 next cycle, time unchanged. i_btn_pos with i_btn_up at o_sel = 0 and sec = 59 -> sec = 0, o_sel = 1, o_min unchanged.
- rst_n pulsed low mid-SET, asynchronously between clock edges -> outputs clear immediately: o_mode = 0, 00:00:00, o_blank = 0, o_sel = 0.
